surf_cmd_decode: RTL

SURF-side receiver for the rackbus command word that the TURFIO splices together and broadcasts once per 8-sysclk command period. Accepts each deserialized 32-bit word with its strobe and lock flag, checks its period, unpacks it into the `RACKBUS_*` fields, and delivers each field to SURF logic as an AXI4-Stream or pulse:

- mode1 data
- firmware-update (FWU) bytes
- FWU mark
- run commands
- triggers
- PPS

---
 rtl/rackbus_pkg.sv | 49 ++++
 rtl/rackbus_byte_fifo.sv | 56 +++++
 rtl/surf_cmd_decode.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rackbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rackbus_pkg
//  Purpose  : Rackbus command-word layout, field accessors and decode constants.
//  Revision : 1.0  initial release
// ============================================================================
package rackbus_pkg;

    // Word layout, MSB first: ignore | pps | runcmd[1:0] | mode1type[1:0] |
    // mode1data[7:0] | trig_valid | trig[16:0]
    localparam int RACKBUS_TRIG_BITS = 17;

    localparam logic [1:0] MODE1_SPECIAL  = 2'd0;
    localparam logic [1:0] MODE1_FWU      = 2'd1;
    localparam logic [7:0] MODE1_NOOP     = 8'h00;
    localparam logic [7:0] MODE1_MARK_FWU = 8'h01;
    localparam logic [1:0] RUNCMD_NOOP    = 2'd0;
    localparam int         CMD_PERIOD     = 8;

    function automatic logic rackbus_ignore(input logic [31:0] cmd);
        return cmd[31];
    endfunction

    function automatic logic rackbus_pps(input logic [31:0] cmd);
        return cmd[30];
    endfunction

    function automatic logic [1:0] rackbus_runcmd(input logic [31:0] cmd);
        return cmd[29:28];
    endfunction

    function automatic logic [1:0] rackbus_mode1type(input logic [31:0] cmd);
        return cmd[27:26];
    endfunction

    function automatic logic [7:0] rackbus_mode1data(input logic [31:0] cmd);
        return cmd[25:18];
    endfunction

    function automatic logic rackbus_trig_valid(input logic [31:0] cmd);
        return cmd[17];
    endfunction

    function automatic logic [RACKBUS_TRIG_BITS-1:0] rackbus_trig(input logic [31:0] cmd);
        return cmd[RACKBUS_TRIG_BITS-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rackbus_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rackbus_byte_fifo
//  Purpose  : Synchronous byte FIFO with full/empty flags and AXI4-S output.
//  Revision : 1.0  initial release
// ============================================================================
module rackbus_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    output logic       o_full,
    output logic       o_empty,
    output logic [7:0] o_tdata,
    input  logic       i_tready
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic        w_pop;
    logic        w_wr;

    always_comb begin
        o_empty  = (wr_ptr_q == rd_ptr_q);
        o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        w_pop    = !o_empty && i_tready;
        w_wr     = i_push && (!o_full || w_pop);
        mem_d    = mem_q;
        if (w_wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = i_push_data;
        end
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, w_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, w_pop};
        o_tdata  = o_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/surf_cmd_decode.sv
`default_nettype none
// ============================================================================
//  Module   : surf_cmd_decode
//  Purpose  : Rackbus command-word receiver: period check, field unpack, streams.
//  Revision : 1.0  initial release
// ============================================================================
module surf_cmd_decode
    import rackbus_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                         sysclk_i,
    input  logic                         sysclk_rst_i,
    input  logic [31:0]                  cmd_i,
    input  logic                         cmd_valid_i,
    input  logic                         cmd_locked_i,
    output logic [7:0]                   mode1_tdata,
    output logic [1:0]                   mode1_tuser,
    output logic                         mode1_tvalid,
    input  logic                         mode1_tready,
    output logic [7:0]                   fw_tdata,
    output logic                         fw_tvalid,
    input  logic                         fw_tready,
    output logic                         fw_mark_o,
    output logic [1:0]                   runcmd_tdata,
    output logic                         runcmd_tvalid,
    input  logic                         runcmd_tready,
    output logic [RACKBUS_TRIG_BITS-1:0] trig_tdata,
    output logic                         trig_tvalid,
    input  logic                         trig_tready,
    output logic                         pps_o,
    output logic                         phase_err_o,
    output logic [15:0]                  err_count_o
);
    localparam logic [3:0] PERIOD_LAST = 4'(CMD_PERIOD - 1);

    logic [3:0]                   per_cnt_q, per_cnt_d;
    logic                         armed_q, armed_d;
    logic                         phase_err_q, phase_err_d;
    logic                         pps_q, pps_d;
    logic                         fw_mark_q, fw_mark_d;
    logic                         fw_push_q, fw_push_d;
    logic [7:0]                   fw_byte_q, fw_byte_d;
    logic                         mode1_valid_q, mode1_valid_d;
    logic [7:0]                   mode1_data_q, mode1_data_d;
    logic [1:0]                   mode1_type_q, mode1_type_d;
    logic                         runcmd_valid_q, runcmd_valid_d;
    logic [1:0]                   runcmd_data_q, runcmd_data_d;
    logic                         trig_valid_q, trig_valid_d;
    logic [RACKBUS_TRIG_BITS-1:0] trig_data_q, trig_data_d;
    logic [15:0]                  err_count_q, err_count_d;

    logic       w_accept, w_live, w_overwrite, w_err, w_fifo_drop;
    logic       w_fifo_full, w_fifo_empty;
    logic [1:0] w_m1type;
    logic [7:0] w_m1data;

    rackbus_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (sysclk_i),
        .rst         (sysclk_rst_i),
        .i_push      (fw_push_q),
        .i_push_data (fw_byte_q),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_tdata     (fw_tdata),
        .i_tready    (fw_tready)
    );

    assign fw_tvalid = !w_fifo_empty;

    always_comb begin
        w_accept = cmd_valid_i && cmd_locked_i && !sysclk_rst_i;
        w_live   = w_accept && !rackbus_ignore(cmd_i);
        w_m1type = rackbus_mode1type(cmd_i);
        w_m1data = rackbus_mode1data(cmd_i);

        // Counter restarts on every strobe; saturating keeps long gaps != 7.
        per_cnt_d = (per_cnt_q == 4'hF) ? per_cnt_q : per_cnt_q + 4'd1;
        if (cmd_valid_i) begin
            per_cnt_d = 4'd0;
        end
        armed_d = cmd_locked_i && (armed_q || w_accept);
        phase_err_d = w_accept && armed_q && (per_cnt_q != PERIOD_LAST);

        pps_d       = w_live && rackbus_pps(cmd_i);
        fw_mark_d   = 1'b0;
        fw_push_d   = 1'b0;
        fw_byte_d   = fw_byte_q;
        w_overwrite = 1'b0;

        trig_valid_d = trig_valid_q && !trig_tready;
        trig_data_d  = trig_data_q;
        if (w_live && rackbus_trig_valid(cmd_i)) begin
            w_overwrite  = w_overwrite || trig_valid_d;
            trig_valid_d = 1'b1;
            trig_data_d  = rackbus_trig(cmd_i);
        end

        runcmd_valid_d = runcmd_valid_q && !runcmd_tready;
        runcmd_data_d  = runcmd_data_q;
        if (w_live && (rackbus_runcmd(cmd_i) != RUNCMD_NOOP)) begin
            w_overwrite    = w_overwrite || runcmd_valid_d;
            runcmd_valid_d = 1'b1;
            runcmd_data_d  = rackbus_runcmd(cmd_i);
        end

        mode1_valid_d = mode1_valid_q && !mode1_tready;
        mode1_data_d  = mode1_data_q;
        mode1_type_d  = mode1_type_q;
        if (w_live) begin
            if (w_m1type == MODE1_SPECIAL && w_m1data == MODE1_MARK_FWU) begin
                fw_mark_d = 1'b1;
            end else if (w_m1type == MODE1_FWU) begin
                fw_push_d = 1'b1;
                fw_byte_d = w_m1data;
            end else if (!(w_m1type == MODE1_SPECIAL && w_m1data == MODE1_NOOP)) begin
                w_overwrite   = w_overwrite || mode1_valid_d;
                mode1_valid_d = 1'b1;
                mode1_data_d  = w_m1data;
                mode1_type_d  = w_m1type;
            end
        end

        // The FIFO sees the byte decoded last cycle; a pop frees room at full.
        w_fifo_drop = fw_push_q && w_fifo_full && !(fw_tvalid && fw_tready);
        w_err       = phase_err_d || w_overwrite || w_fifo_drop;
        err_count_d = (w_err && err_count_q != 16'hFFFF) ? err_count_q + 16'd1
                                                        : err_count_q;
    end

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            per_cnt_q      <= '0;
            armed_q        <= 1'b0;
            phase_err_q    <= 1'b0;
            pps_q          <= 1'b0;
            fw_mark_q      <= 1'b0;
            fw_push_q      <= 1'b0;
            fw_byte_q      <= '0;
            mode1_valid_q  <= 1'b0;
            mode1_data_q   <= '0;
            mode1_type_q   <= '0;
            runcmd_valid_q <= 1'b0;
            runcmd_data_q  <= '0;
            trig_valid_q   <= 1'b0;
            trig_data_q    <= '0;
            err_count_q    <= '0;
        end else begin
            per_cnt_q      <= per_cnt_d;
            armed_q        <= armed_d;
            phase_err_q    <= phase_err_d;
            pps_q          <= pps_d;
            fw_mark_q      <= fw_mark_d;
            fw_push_q      <= fw_push_d;
            fw_byte_q      <= fw_byte_d;
            mode1_valid_q  <= mode1_valid_d;
            mode1_data_q   <= mode1_data_d;
            mode1_type_q   <= mode1_type_d;
            runcmd_valid_q <= runcmd_valid_d;
            runcmd_data_q  <= runcmd_data_d;
            trig_valid_q   <= trig_valid_d;
            trig_data_q    <= trig_data_d;
            err_count_q    <= err_count_d;
        end
    end

    assign mode1_tdata   = mode1_data_q;
    assign mode1_tuser   = mode1_type_q;
    assign mode1_tvalid  = mode1_valid_q;
    assign runcmd_tdata  = runcmd_data_q;
    assign runcmd_tvalid = runcmd_valid_q;
    assign trig_tdata    = trig_data_q;
    assign trig_tvalid   = trig_valid_q;
    assign fw_mark_o     = fw_mark_q;
    assign pps_o         = pps_q;
    assign phase_err_o   = phase_err_q;
    assign err_count_o   = err_count_q;

endmodule
`default_nettype wire
